// File: rtl/adder_pipe_pkg.sv
// Shared types and the golden add/subtract model for the adder_pipe block.
package adder_pipe_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

   localparam int unsigned REF_MAX_W = 64;
   localparam logic [REF_MAX_W:0] REF_ONE = {{REF_MAX_W{1'b0}}, 1'b1};

   // Operands must be zero above bit width-1; result bit [width] is carry (ADD) or borrow (SUB).
   function automatic logic [REF_MAX_W:0] ref_result(input logic [REF_MAX_W-1:0] a,
                                                     input logic [REF_MAX_W-1:0] b,
                                                     input op_e                  op,
                                                     input int unsigned          width);
      logic [REF_MAX_W:0] low_mask;
      logic [REF_MAX_W:0] r;
      low_mask = (REF_ONE << width) - REF_ONE;
      if (op == OP_ADD) begin
         r = {1'b0, a} + {1'b0, b};
      end else begin
         r = ({1'b0, a} - {1'b0, b}) & low_mask;
         if (a < b) r = r | (REF_ONE << width);
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle between producer, adder_pipe and consumer.
interface adder_pipe_if
   import adder_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_e              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   y;

   modport master (output in_valid, a, b, op, out_ready,
                   input  in_ready, out_valid, y);
   modport slave  (input  in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, y);
endinterface

// File: rtl/adder_pipe_assertion.sv
// Bound protocol/result checker for adder_pipe, tracking expected results alongside the pipe.
module adder_pipe_assertion
   import adder_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input logic             clk,
   input logic             rst_n,
   input logic             in_valid,
   input logic             in_ready,
   input logic [WIDTH-1:0] a,
   input logic [WIDTH-1:0] b,
   input logic             op,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH:0]   y
);
   logic              adv;
   logic [WIDTH:0]    exp_q [STAGES];
   logic [STAGES-1:0] exp_v_q;

   assign adv = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_v_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) exp_q[k] <= '0;
      end else if (adv) begin
         exp_v_q[0] <= in_valid && in_ready;
         exp_q[0]   <= (WIDTH+1)'(ref_result(REF_MAX_W'(a), REF_MAX_W'(b), op_e'(op), WIDTH));
         for (int unsigned k = 1; k < STAGES; k++) begin
            exp_v_q[k] <= exp_v_q[k-1];
            exp_q[k]   <= exp_q[k-1];
         end
      end
   end

   a_ready:  assert property (@(posedge clk) in_ready == adv);
   a_stall:  assert property (@(posedge clk) disable iff (!rst_n)
                              (out_valid && !out_ready) |=> (out_valid && $stable(y)));
   a_valid:  assert property (@(posedge clk) disable iff (!rst_n) out_valid == exp_v_q[STAGES-1]);
   a_result: assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> (y == exp_q[STAGES-1]));
   a_reset:  assert property (@(posedge clk) !rst_n |=> (!out_valid && (y == '0)));
endmodule

bind adder_pipe adder_pipe_assertion #(
   .WIDTH  (WIDTH),
   .STAGES (STAGES)
) u_adder_pipe_assertion (
   .clk       (clk),
   .rst_n     (rst_n),
   .in_valid  (in_valid_w),
   .in_ready  (adv),
   .a         (a_w),
   .b         (b_w),
   .op        (op_w),
   .out_valid (out_valid_w),
   .out_ready (out_ready_w),
   .y         (y_w)
);

// File: rtl/adder_pipe_slice.sv
// Combinational SW-bit ripple slice with carry in/out; one per pipeline stage.
module adder_slice #(
   parameter int unsigned SW = 4
) (
   input  logic [SW-1:0] a_i,
   input  logic [SW-1:0] b_i,
   input  logic          c_i,
   output logic [SW-1:0] s_o,
   output logic          c_o
);
   always_comb begin
      {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
   end
endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: carry chain split into STAGES registered slices, valid/ready flow control.
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input logic        clk,
   input logic        rst_n,
   adder_pipe_if.slave bus
);
   localparam int unsigned SW = WIDTH / STAGES;

   logic             in_valid_w, out_ready_w, op_w, out_valid_w, adv, accept;
   logic [WIDTH-1:0] a_w, b_w, b_cap;
   logic [WIDTH:0]   y_w;

   logic [STAGES-1:0]            vld_q, vld_d, op_q, op_d, cy_q, cy_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d;

   logic [STAGES-1:0][SW-1:0] sl_a, sl_b, sl_s;
   logic [STAGES-1:0]         sl_c, sl_co;

   assign in_valid_w  = bus.in_valid;
   assign out_ready_w = bus.out_ready;
   assign a_w         = bus.a;
   assign b_w         = bus.b;
   assign op_w        = (bus.op == OP_SUB);
   assign b_cap       = op_w ? ~b_w : b_w;

   assign out_valid_w = vld_q[STAGES-1];
   assign y_w         = {cy_q[STAGES-1] ^ op_q[STAGES-1], sum_q[STAGES-1]};
   assign adv         = !out_valid_w || out_ready_w;
   assign accept      = in_valid_w && adv;

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_w;
   assign bus.y         = y_w;

   // Stage 0 adds straight from the inputs; stage k adds slice k of the operands carried by stage k-1.
   always_comb begin
      sl_a    = '0;
      sl_b    = '0;
      sl_c    = '0;
      sl_a[0] = a_w[SW-1:0];
      sl_b[0] = b_cap[SW-1:0];
      sl_c[0] = op_w;
      for (int unsigned k = 1; k < STAGES; k++) begin
         sl_a[k] = a_q[k-1][k*SW +: SW];
         sl_b[k] = b_q[k-1][k*SW +: SW];
         sl_c[k] = cy_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(.SW(SW)) u_slice (
         .a_i (sl_a[k]),
         .b_i (sl_b[k]),
         .c_i (sl_c[k]),
         .s_o (sl_s[k]),
         .c_o (sl_co[k])
      );
   end

   always_comb begin
      vld_d = vld_q;
      op_d  = op_q;
      cy_d  = cy_q;
      sum_d = sum_q;
      a_d   = a_q;
      b_d   = b_q;
      if (adv) begin
         vld_d[0]          = accept;
         op_d[0]           = op_w;
         a_d[0]            = a_w;
         b_d[0]            = b_cap;
         sum_d[0]          = '0;
         sum_d[0][SW-1:0]  = sl_s[0];
         cy_d[0]           = sl_co[0];
         for (int unsigned k = 1; k < STAGES; k++) begin
            vld_d[k]             = vld_q[k-1];
            op_d[k]              = op_q[k-1];
            a_d[k]               = a_q[k-1];
            b_d[k]               = b_q[k-1];
            sum_d[k]             = sum_q[k-1];
            sum_d[k][k*SW +: SW] = sl_s[k];
            cy_d[k]              = sl_co[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         op_q  <= '0;
         cy_q  <= '0;
         sum_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         vld_q <= vld_d;
         op_q  <= op_d;
         cy_q  <= cy_d;
         sum_q <= sum_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   // Already-consumed low slices and the last stage's operand copy are never read again.
   logic unused_operands;
   assign unused_operands = ^{a_q, b_q};
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 8-bit/2-stage main instance plus a 4-bit/4-stage corner instance.
module tb_adder_pipe;
   import adder_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   adder_pipe_if #(.WIDTH(8)) bus8 ();
   adder_pipe_if #(.WIDTH(4)) bus4 ();

   adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   adder_pipe #(.WIDTH(4), .STAGES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input op_e op, input logic [8:0] exp);
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.op = op;
      #1 check_eq({tag, "_rdy"}, 64'(bus8.in_ready), 64'd1);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      check_eq({tag, "_early"}, 64'(bus8.out_valid), 64'd0);
      @(negedge clk);
      check_eq({tag, "_vld"}, 64'(bus8.out_valid), 64'd1);
      check_eq({tag, "_y"}, 64'(bus8.y), 64'(exp));
   endtask

   task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input op_e op, input logic [4:0] exp);
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.a = a; bus4.b = b; bus4.op = op;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq({tag, "_early"}, 64'(bus4.out_valid), 64'd0);
         @(negedge clk);
      end
      check_eq({tag, "_vld"}, 64'(bus4.out_valid), 64'd1);
      check_eq({tag, "_y"}, 64'(bus4.y), 64'(exp));
   endtask

   task automatic drain8();
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [8:0]  exp_q [$];
      int unsigned acc;
      int unsigned cyc;

      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = OP_ADD; bus8.out_ready = 1'b1;
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.op = OP_ADD; bus4.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_vld8", 64'(bus8.out_valid), 64'd0);
      check_eq("rst_y8",   64'(bus8.y),         64'd0);
      check_eq("rst_rdy8", 64'(bus8.in_ready),  64'd1);
      check_eq("rst_vld4", 64'(bus4.out_valid), 64'd0);
      check_eq("rst_y4",   64'(bus4.y),         64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, 8-bit / 2-stage
      op8("add_200_100", 8'd200, 8'd100, OP_ADD, 9'h12C);
      op8("sub_5_7",     8'd5,   8'd7,   OP_SUB, 9'h1FE);
      op8("sub_7_5",     8'd7,   8'd5,   OP_SUB, 9'h002);
      op8("add_ff_ff",   8'hFF,  8'hFF,  OP_ADD, 9'h1FE);
      op8("sub_0_0",     8'h00,  8'h00,  OP_SUB, 9'h000);
      op8("sub_0_1",     8'h00,  8'h01,  OP_SUB, 9'h1FF);

      // Backpressure: A, B, C back-to-back, then 4-cycle stall on B
      drain8();
      bus8.in_valid = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.op = OP_ADD;
      @(negedge clk);
      bus8.a = 8'h10; bus8.b = 8'h01; bus8.op = OP_SUB;
      @(negedge clk);
      check_eq("bp_a_vld", 64'(bus8.out_valid), 64'd1);
      check_eq("bp_a_y",   64'(bus8.y),         64'h003);
      bus8.a = 8'h80; bus8.b = 8'h80; bus8.op = OP_ADD;
      @(negedge clk);
      bus8.a = 8'h55; bus8.b = 8'h55; bus8.op = OP_ADD;
      bus8.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check_eq("bp_stall_vld", 64'(bus8.out_valid), 64'd1);
         check_eq("bp_stall_y",   64'(bus8.y),         64'h00F);
         check_eq("bp_stall_rdy", 64'(bus8.in_ready),  64'd0);
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_c_vld", 64'(bus8.out_valid), 64'd1);
      check_eq("bp_c_y",   64'(bus8.y),         64'h100);
      @(negedge clk);
      check_eq("bp_empty", 64'(bus8.out_valid), 64'd0);

      // Reset with two ops in flight, plus an op offered during reset
      drain8();
      bus8.out_ready = 1'b0;
      bus8.in_valid = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.op = OP_ADD;
      @(negedge clk);
      bus8.a = 8'h40; bus8.b = 8'h01; bus8.op = OP_SUB;
      #1 check_eq("mr_rdy", 64'(bus8.in_ready), 64'd1);
      @(negedge clk);
      check_eq("mr_d_vld", 64'(bus8.out_valid), 64'd1);
      check_eq("mr_d_y",   64'(bus8.y),         64'h033);
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.op = OP_ADD;
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mr_vld", 64'(bus8.out_valid), 64'd0);
      check_eq("mr_y",   64'(bus8.y),         64'd0);
      check_eq("mr_rdy_in_rst", 64'(bus8.in_ready), 64'd1);
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("mr_no_emerge", 64'(bus8.out_valid), 64'd0);
      end

      // Random soak against the package reference model
      acc = 0;
      cyc = 0;
      while ((acc < 1000 || exp_q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc < 1000) begin
            bus8.in_valid = ($urandom_range(0, 3) != 0);
            bus8.a        = 8'($urandom);
            bus8.b        = 8'($urandom);
            bus8.op       = op_e'($urandom_range(0, 1));
         end else begin
            bus8.in_valid = 1'b0;
         end
         bus8.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (bus8.in_valid && bus8.in_ready) begin
            exp_q.push_back(9'(ref_result(64'(bus8.a), 64'(bus8.b), bus8.op, 8)));
            acc++;
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) check_eq("soak_extra", 64'd1, 64'(exp_q.size()));
            else                   check_eq("soak_y", 64'(bus8.y), 64'(exp_q.pop_front()));
         end
      end
      check_eq("soak_accepted", 64'(acc), 64'd1000);
      check_eq("soak_drained",  64'(exp_q.size()), 64'd0);
      drain8();

      // Corner configuration, 4-bit / 4-stage
      op4("c4_add_15_15", 4'd15, 4'd15, OP_ADD, 5'h1E);
      op4("c4_sub_0_1",   4'd0,  4'd1,  OP_SUB, 5'h1F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit with valid/ready handshakes. It generalises the team's combinational 4-bit adder in three ways: width is a parameter, the carry chain is split across registered stages, and a per-transaction op select chooses add or subtract. It sits between an operand producer and a result consumer, and it accepts one operation per cycle when it is not stalled.

## Interface
- `WIDTH`, default 8 — operand width in bits. Must be ≥ 2.
- `STAGES`, default 2 — number of pipeline stages. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0.
- `clk` in 1 — single clock. All logic is on the rising edge.
- `rst_n` in 1 — reset, synchronous and active-low.
- `in_valid` in 1 — operands and op are presented.
- `in_ready` out 1 — block can accept this cycle.
- `a` in WIDTH — first operand, unsigned.
- `b` in WIDTH — second operand, unsigned.
- `op` in 1 — 0 = ADD, 1 = SUB.
- `out_valid` out 1 — `y` holds a result.
- `out_ready` in 1 — consumer accepts the result.
- `y` out WIDTH+1 — result (see Operation).

## Operation
- Slice width: SW = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k·SW +: SW].
  - Carry-in to stage k is the registered carry from stage k-1.
  - Carry-in to stage 0 is `op`.
- Subtraction: `b` is bitwise inverted at input capture, when `op` = 1. Add and subtract then share the same datapath.
- Result definition:
  - ADD: y = a + b, with y[WIDTH] = final carry.
  - SUB: y[WIDTH-1:0] = (a − b) mod 2^WIDTH, with y[WIDTH] = borrow = NOT final carry. y[WIDTH] = 1 exactly when a < b.
- Each stage register holds:
  - a valid bit;
  - the sum bits completed so far;
  - the not-yet-added upper operand slices;
  - the op bit;
  - the carry.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Accept = in_valid && in_ready.
- When adv = 1, every stage shifts forward by one, and stage 0 loads the new input.
  - Stage 0's valid = accept.
  - Bubbles propagate as valid = 0 and are not collapsed.
- When adv = 0, all stage registers hold their contents.
- `y` and `out_valid` come directly from the final stage register. There is no combinational input→output path.
- Reset (`rst_n` = 0 at a clock edge):
  - all stage valid bits → 0, out_valid → 0, y → 0, all data registers → 0;
  - in-flight transactions are discarded.
  - During reset, in_ready = 1, because out_valid = 0. Inputs presented while `rst_n` = 0 are not captured.

## Timing
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N+STAGES−1, i.e. STAGES cycles after capture, assuming no stall.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0.
  - y and out_valid stay stable until the handshake completes.
  - in_ready = 0 in the same cycle.
- Simultaneous handshake: a result leaves and a new input enters on the same edge (out_valid && out_ready && in_valid). This is required for full throughput.
- Boundary values that must hold:
  - ADD of all-ones + all-ones → y = 2^(WIDTH+1) − 2.
  - SUB of 0 − 0 → y = 0, borrow 0.
  - SUB of 0 − 1 → y = 2^(WIDTH+1) − 1.
- STAGES = 1: single registered adder, latency 1.

## Structure
- Package `adder_pipe_pkg` holds:
  - `typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e`;
  - a function giving the reference result `(a, b, op) → WIDTH+1` bits, shared by the RTL assertions and the bench scoreboard.
- Sub-module `adder_slice`: combinational SW-bit full adder with carry-in and carry-out. It is instantiated once per stage via generate.
- SVA checker `adder_pipe_assertion` is bound to `adder_pipe` and checks:
  - stability of y and out_valid under stall;
  - in_ready == adv;
  - result correctness STAGES accepts later;
  - all outputs at 0 after reset.

## Test plan
- WIDTH=8, STAGES=2, out_ready=1: ADD 200+100 → out_valid two cycles after accept, y=0x12C.
- SUB 5−7 → y=0x1FE. SUB 7−5 → y=0x002. ADD 0xFF+0xFF → y=0x1FE.
- Backpressure: push 3 ops back-to-back, hold out_ready=0 for 4 cycles → y is stable, in_ready=0, no op is lost or duplicated; release → 3 results in order on consecutive cycles.
- Reset mid-flight: assert rst_n=0 while 2 ops are in the pipe → next cycle out_valid=0 and y=0; neither op ever emerges.
- Random soak: 1000 random a/b/op with random in_valid/out_ready → the scoreboard matches the package reference function in order, and all bound assertions pass.
- Corner configuration WIDTH=4, STAGES=4: ADD 15+15 → y=30 after 4 cycles; SUB 0−1 → y=0x1F.
